priority_encoder8x3: RTL and testbench
======================================

// Module: priority_encoder8x3
// PURPOSE
// - Registered 8-to-3 priority encoder with request capture and a valid/ack handshake.
// - Latches request lines Y7..Y0 into a pending register.
// - Presents the winning index as a 3-bit code A2..A0 and holds it until it is acknowledged.
// - Sits upstream of decoder3x8-style select logic; in the source-select path it is the inverse of the 3x8 decode.
// PARAMETERS
// - HIGH_FIRST   1  1: highest pending index wins (Y7 top); 0: lowest index wins (Y0 top).
// - EDGE_DETECT  0  0: any cycle with Y[i]=1 sets pending[i]; 1: only a 0->1 transition of Y[i] sets it.
// PORTS
// - clk      in   1  single clock; all state updates on the rising edge.
// - rst_n    in   1  synchronous reset, active low.
// - Y        in   8  request lines, Y[7]..Y[0].
// - mask     in   8  1 = request i eligible to win; a masked bit still accumulates in pending.
// - ack      in   1  consumer accepts the presented code; sampled only when valid=1.
// - A        out  3  encoded index {A2,A1,A0}; registered.
// - valid    out  1  A holds a granted index; registered.
// - pend     out  8  current pending register, direct register output.
// BEHAVIOUR
// - Reset: sampled at a rising edge while rst_n=0. Takes priority over every other event, including mid-handshake.
//   - pending=0, A=0, valid=0, state=IDLE.
//   - Edge-detect history register = 0, so a Y bit held high through reset is seen as a rising edge after release.
// - Capture, every edge:
//   - req_set = EDGE_DETECT ? (Y & ~Y_q) : Y.
//   - Y_q <= Y.
//   - pending <= (pending & ~clr) | req_set.
//   - Set wins over clear on the same bit.
// - Winner:
//   - elig = pending & mask, using the registered pending value.
//   - Winner index is taken from elig by priority order per HIGH_FIRST.
// - FSM: 2 states.
//   - IDLE: if elig!=0, then A<=winner, valid<=1, go to PRESENT. Otherwise hold; valid stays 0.
//   - PRESENT: A and valid hold stable regardless of changes on Y, mask or pending.
//     - On an edge with ack=1: clr = onehot(A), valid<=0, go to IDLE.
//     - A keeps its last value while valid=0.
// - Latency:
//   - Y[i] is high at edge k, so pending[i]=1 after edge k. With the FSM in IDLE and i winning, valid=1 and A=i after edge k+1.
//   - After ack at edge m, valid=0 for at least the cycle after m. The next grant can appear after edge m+1.
// - ack while valid=0: ignored, no clear.
// - mask[A] dropping to 0 in PRESENT does not retract the grant; the grant completes normally.
// - All bits masked: pending still accumulates, valid stays 0. Unmasking grants one edge later.
// - Y[A]=1 on the ack edge:
//   - Level mode: bit stays pending and is granted again.
//   - Edge mode: bit is re-set only if that edge is a new rising edge.
// - No counting: repeat requests on an already-pending bit merge into one grant.
// TESTING
// - Reset: hold rst_n=0 two edges with Y=8'hFF, mask=8'hFF. Required: pend=0, valid=0, A=0. Edge mode: pend=8'hFF one edge after release.
// - Single request: Y=8'h20 for one cycle at edge k, mask=8'hFF. Required: pend=8'h20 after k; valid=1, A=5 after k+1. Ack then gives pend=0, valid=0.
// - Priority: pend=8'h89, HIGH_FIRST=1. Required grant sequence A=7,3,0, each released by ack, with at least one valid=0 cycle between grants. Same stimulus with HIGH_FIRST=0 requires A=0,3,7.
// - Mask: pend=8'h81, mask=8'h7F. Required: A=0. Set mask=8'h00 while valid=1: A=0 holds until ack. With pend=8'h80, valid stays 0 until mask[7]=1.
// - Simultaneous events: ack with Y[A]=1 in level mode: bit stays pending and is re-granted. Edge mode with Y held high: bit is cleared. ack while valid=0: pend unchanged.
// - Reset mid-handshake: valid=1, A=4, assert rst_n=0 for one edge with ack=1. Required: valid=0, pend=0, state IDLE; no stale grant after release.

Source files
------------

// File: rtl/priority_encoder8x3.sv
// Registered 8-to-3 priority encoder. Requests accumulate in a pending register,
// and the winning index is presented with a valid/ack handshake.
module priority_encoder8x3 #(
  parameter bit HIGH_FIRST  = 1'b1,
  parameter bit EDGE_DETECT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] Y,
  input  logic [7:0] mask,
  input  logic       ack,
  output logic [2:0] A,
  output logic       valid,
  output logic [7:0] pend
);

  typedef enum logic [0:0] {StIdle, StPresent} state_e;

  state_e     state_q, state_d;
  logic [7:0] y_q, y_d;
  logic [7:0] pend_q, pend_d;
  logic [2:0] a_q, a_d;
  logic       valid_q, valid_d;

  logic [7:0] req_set;
  logic [7:0] clr;
  logic [7:0] elig;
  logic [2:0] winner;

  assign elig = pend_q & mask;

  // Scan order makes the last eligible index seen the winner.
  always_comb begin
    winner = '0;
    if (HIGH_FIRST) begin
      for (int i = 0; i < 8; i++) begin
        if (elig[i]) winner = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (elig[i]) winner = 3'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    valid_d = valid_q;
    clr     = '0;
    unique case (state_q)
      StIdle: begin
        if (|elig) begin
          a_d     = winner;
          valid_d = 1'b1;
          state_d = StPresent;
        end
      end
      StPresent: begin
        if (ack) begin
          clr     = 8'b1 << a_q;
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // A set on the same edge as its clear wins, so re-requests are not lost.
  always_comb begin
    req_set = EDGE_DETECT ? (Y & ~y_q) : Y;
    pend_d  = (pend_q & ~clr) | req_set;
    y_d     = Y;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      y_q     <= '0;
      pend_q  <= '0;
      a_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      pend_q  <= pend_d;
      a_q     <= a_d;
      valid_q <= valid_d;
    end
  end

  assign A     = a_q;
  assign valid = valid_q;
  assign pend  = pend_q;

endmodule

// File: tb/tb_priority_encoder8x3.sv
// Bench for priority_encoder8x3: four parameter variants share one stimulus stream
// and are compared every cycle against a behavioural model, plus directed checks.
module tb_priority_encoder8x3;

  logic       clk;
  logic       rst_n;
  logic [7:0] y;
  logic [7:0] mask;
  logic       ack;
  logic [2:0] dut_a     [4];
  logic       dut_valid [4];
  logic [7:0] dut_pend  [4];

  int checks   = 0;
  int failures = 0;

  // Variant c: HIGH_FIRST = (c is even), EDGE_DETECT = (c >= 2).
  priority_encoder8x3 #(.HIGH_FIRST(1'b1), .EDGE_DETECT(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .Y(y), .mask(mask), .ack(ack),
    .A(dut_a[0]), .valid(dut_valid[0]), .pend(dut_pend[0]));
  priority_encoder8x3 #(.HIGH_FIRST(1'b0), .EDGE_DETECT(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .Y(y), .mask(mask), .ack(ack),
    .A(dut_a[1]), .valid(dut_valid[1]), .pend(dut_pend[1]));
  priority_encoder8x3 #(.HIGH_FIRST(1'b1), .EDGE_DETECT(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .Y(y), .mask(mask), .ack(ack),
    .A(dut_a[2]), .valid(dut_valid[2]), .pend(dut_pend[2]));
  priority_encoder8x3 #(.HIGH_FIRST(1'b0), .EDGE_DETECT(1'b1)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .Y(y), .mask(mask), .ack(ack),
    .A(dut_a[3]), .valid(dut_valid[3]), .pend(dut_pend[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, one entry per variant.
  bit [7:0] m_pend  [4];
  bit [7:0] m_yprev [4];
  int       m_a     [4];
  bit       m_busy  [4];

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Index of the winning set bit: highest if hf, else lowest; -1 if none.
  function automatic int pick(input bit [7:0] v, input bit hf);
    int r = -1;
    for (int i = 0; i < 8; i++) begin
      if (v[i] && (hf || r < 0)) r = i;
    end
    return r;
  endfunction

  task automatic model_step(input int c);
    bit       hf = (c % 2 == 0);
    bit       ed = (c >= 2);
    bit [7:0] set_v;
    bit [7:0] clr_v;
    bit [7:0] elig_v;
    if (!rst_n) begin
      m_pend[c] = 0; m_yprev[c] = 0; m_a[c] = 0; m_busy[c] = 0;
      return;
    end
    set_v  = ed ? (y & ~m_yprev[c]) : y;
    clr_v  = (m_busy[c] && ack) ? 8'(1 << m_a[c]) : 8'h00;
    elig_v = m_pend[c] & mask;
    if (m_busy[c]) begin
      if (ack) m_busy[c] = 0;
    end else if (elig_v != 0) begin
      m_a[c]    = pick(elig_v, hf);
      m_busy[c] = 1;
    end
    m_pend[c]  = (m_pend[c] & ~clr_v) | set_v;
    m_yprev[c] = y;
  endtask

  // One clock: advance the model, let the DUTs clock, then compare after the edge.
  task automatic tick();
    for (int c = 0; c < 4; c++) model_step(c);
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      check_eq($sformatf("model_pend_v%0d", c), dut_pend[c], m_pend[c]);
      check_eq($sformatf("model_valid_v%0d", c), {7'b0, dut_valid[c]}, {7'b0, m_busy[c]});
      check_eq($sformatf("model_a_v%0d", c), {5'b0, dut_a[c]}, 8'(m_a[c]));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; y = 8'h00; mask = 8'hFF; ack = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; y = 8'hFF; mask = 8'hFF; ack = 1'b0;

    // Reset with all requests high; edge mode sees them as new after release.
    tick();
    tick();
    check_eq("rst_pend", dut_pend[0], 8'h00);
    check_eq("rst_valid", {7'b0, dut_valid[0]}, 8'h00);
    check_eq("rst_a", {5'b0, dut_a[0]}, 8'h00);
    rst_n = 1'b1;
    tick();
    check_eq("rst_edge_pend", dut_pend[2], 8'hFF);

    // Single request on bit 5.
    do_reset();
    y = 8'h20;
    tick();
    check_eq("single_pend", dut_pend[0], 8'h20);
    check_eq("single_valid_early", {7'b0, dut_valid[0]}, 8'h00);
    y = 8'h00;
    tick();
    check_eq("single_valid", {7'b0, dut_valid[0]}, 8'h01);
    check_eq("single_a", {5'b0, dut_a[0]}, 8'h05);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_eq("single_ack_valid", {7'b0, dut_valid[0]}, 8'h00);
    check_eq("single_ack_pend", dut_pend[0], 8'h00);

    // Priority order for pend=8'h89 in both directions.
    do_reset();
    y = 8'h89;
    tick();
    y = 8'h00;
    tick();
    check_eq("prio_hi_1", {5'b0, dut_a[0]}, 8'h07);
    check_eq("prio_lo_1", {5'b0, dut_a[1]}, 8'h00);
    ack = 1'b1; tick(); ack = 1'b0;
    check_eq("prio_gap_valid", {7'b0, dut_valid[0]}, 8'h00);
    tick();
    check_eq("prio_hi_2", {5'b0, dut_a[0]}, 8'h03);
    check_eq("prio_lo_2", {5'b0, dut_a[1]}, 8'h03);
    ack = 1'b1; tick(); ack = 1'b0;
    tick();
    check_eq("prio_hi_3", {5'b0, dut_a[0]}, 8'h00);
    check_eq("prio_lo_3", {5'b0, dut_a[1]}, 8'h07);
    ack = 1'b1; tick(); ack = 1'b0;
    check_eq("prio_done_pend", dut_pend[0], 8'h00);

    // Masking: mask drop during a grant does not retract it.
    do_reset();
    y = 8'h81; mask = 8'h7F;
    tick();
    y = 8'h00;
    tick();
    check_eq("mask_a", {5'b0, dut_a[0]}, 8'h00);
    mask = 8'h00;
    tick();
    check_eq("mask_hold_valid", {7'b0, dut_valid[0]}, 8'h01);
    check_eq("mask_hold_a", {5'b0, dut_a[0]}, 8'h00);
    ack = 1'b1; tick(); ack = 1'b0;
    check_eq("mask_left_pend", dut_pend[0], 8'h80);
    tick();
    tick();
    check_eq("mask_all_valid", {7'b0, dut_valid[0]}, 8'h00);
    mask = 8'hFF;
    tick();
    check_eq("unmask_valid", {7'b0, dut_valid[0]}, 8'h01);
    check_eq("unmask_a", {5'b0, dut_a[0]}, 8'h07);
    ack = 1'b1; tick(); ack = 1'b0;

    // Ack with the granted request still high.
    do_reset();
    y = 8'h20;
    tick();
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_eq("lvl_reack_pend", dut_pend[0], 8'h20);
    check_eq("edge_reack_pend", dut_pend[2], 8'h00);
    tick();
    check_eq("lvl_regrant", {7'b0, dut_valid[0]}, 8'h01);
    check_eq("edge_no_regrant", {7'b0, dut_valid[2]}, 8'h00);
    y = 8'h00;
    ack = 1'b1; tick(); ack = 1'b0;

    // Ack while idle is ignored.
    do_reset();
    mask = 8'h00; y = 8'h04;
    tick();
    y = 8'h00; ack = 1'b1;
    tick();
    ack = 1'b0;
    check_eq("idle_ack_pend", dut_pend[0], 8'h04);

    // Reset in the middle of a handshake.
    do_reset();
    y = 8'h10;
    tick();
    y = 8'h00;
    tick();
    check_eq("midrst_a_before", {5'b0, dut_a[0]}, 8'h04);
    rst_n = 1'b0; ack = 1'b1;
    tick();
    rst_n = 1'b1; ack = 1'b0;
    check_eq("midrst_valid", {7'b0, dut_valid[0]}, 8'h00);
    check_eq("midrst_pend", dut_pend[0], 8'h00);
    tick();
    check_eq("midrst_no_stale", {7'b0, dut_valid[0]}, 8'h00);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      y     = 8'($urandom) & 8'($urandom) & 8'($urandom);
      mask  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      ack   = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
